// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- MEM/WB pipeline register and write-back logic for the pipelined
// MIPS core.
//
// This stage holds the instruction that has left MEM. From that registered
// instruction it extracts and extends the load data, drives the register-file
// write port, flags misaligned loads and counts retired instructions. The
// write port (d, wn, we) also feeds the ID-stage forwarding comparators.
//
// Ports
//   clk      in   rising-edge clock
//   clr      in   asynchronous, active-high reset
//   m_valid  in   MEM stage holds a real instruction
//   m_wreg   in   instruction writes a register
//   m_m2reg  in   1: write-back source is load data, 0: ALU result
//   m_rn     in   [4:0] destination register number
//   m_alu    in   [WIDTH-1:0] ALU result / effective address
//   m_mem    in   [WIDTH-1:0] word read from data memory (word-aligned)
//   m_ldt    in   [2:0] load type (000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu,
//                 any other code behaves as lw)
//   stall    in   hold WB contents this cycle
//   flush    in   replace the incoming instruction with a bubble
//   d        out  [WIDTH-1:0] register-file write data (driven even if we=0)
//   wn       out  [4:0] register-file write number
//   we       out  register-file write enable
//   w_exc    out  misaligned-load exception, one pulse per faulting load
//   instret  out  [CNT_W-1:0] retired-instruction count, wraps
//
// Handshake: there is no valid/ready pair on this stage. An instruction sitting
// in WB commits on the one cycle where it is valid and stall is low; that is
// the cycle it leaves WB. stall takes priority over flush, and flush only
// affects the incoming instruction, never the one already in WB.
//
// All outputs are functions of registered state and stall only, so they are
// glitch-free relative to clk.
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             m_valid,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic [4:0]       m_rn,
  input  logic [WIDTH-1:0] m_alu,
  input  logic [WIDTH-1:0] m_mem,
  input  logic [2:0]       m_ldt,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] d,
  output logic [4:0]       wn,
  output logic             we,
  output logic             w_exc,
  output logic [CNT_W-1:0] instret
);

  // Load-type encodings. Codes 101..111 fall into the lw behaviour.
  localparam logic [2:0] LDT_LW  = 3'b000;
  localparam logic [2:0] LDT_LB  = 3'b001;
  localparam logic [2:0] LDT_LBU = 3'b010;
  localparam logic [2:0] LDT_LH  = 3'b011;
  localparam logic [2:0] LDT_LHU = 3'b100;

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  logic             valid_q, valid_d;
  logic             wreg_q,  wreg_d;
  logic             m2reg_q, m2reg_d;
  logic [4:0]       rn_q,    rn_d;
  logic [WIDTH-1:0] alu_q,   alu_d;
  logic [WIDTH-1:0] mem_q,   mem_d;
  logic [2:0]       ldt_q,   ldt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Derived write-back controls
  logic             commit;
  logic             misalign;
  logic             retire;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [WIDTH-1:0] load_data;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q   <= 1'b0;
      wreg_q    <= 1'b0;
      m2reg_q   <= 1'b0;
      rn_q      <= 5'd0;
      alu_q     <= '0;
      mem_q     <= '0;
      ldt_q     <= 3'd0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wreg_q    <= wreg_d;
      m2reg_q   <= m2reg_d;
      rn_q      <= rn_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      ldt_q     <= ldt_d;
      instret_q <= instret_d;
    end
  end

  // Next-state of the pipeline fields. stall is checked first so that a
  // simultaneous flush cannot destroy a held instruction.
  always_comb begin
    valid_d = valid_q;
    wreg_d  = wreg_q;
    m2reg_d = m2reg_q;
    rn_d    = rn_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    ldt_d   = ldt_q;
    if (!stall) begin
      if (flush) begin
        valid_d = 1'b0;
        wreg_d  = 1'b0;
        m2reg_d = 1'b0;
        rn_d    = 5'd0;
        alu_d   = '0;
        mem_d   = '0;
        ldt_d   = 3'd0;
      end else begin
        valid_d = m_valid;
        wreg_d  = m_wreg;
        m2reg_d = m_m2reg;
        rn_d    = m_rn;
        alu_d   = m_alu;
        mem_d   = m_mem;
        ldt_d   = m_ldt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Misalignment detection (loads only)
  // ---------------------------------------------------------------------------
  always_comb begin
    misalign = 1'b0;
    if (m2reg_q) begin
      unique case (ldt_q)
        LDT_LB, LDT_LBU: misalign = 1'b0;
        LDT_LH, LDT_LHU: misalign = alu_q[0];
        default:         misalign = (alu_q[1:0] != 2'b00);
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Big-endian lane selection and extension
  // ---------------------------------------------------------------------------
  // Address offset 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = mem_q[31:24];
    unique case (alu_q[1:0])
      2'd0: byte_lane = mem_q[31:24];
      2'd1: byte_lane = mem_q[23:16];
      2'd2: byte_lane = mem_q[15:8];
      2'd3: byte_lane = mem_q[7:0];
    endcase
  end

  assign half_lane = alu_q[1] ? mem_q[15:0] : mem_q[31:16];

  always_comb begin
    load_data = mem_q;
    unique case (ldt_q)
      LDT_LB:  load_data = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
      LDT_LBU: load_data = {{(WIDTH-8){1'b0}}, byte_lane};
      LDT_LH:  load_data = {{(WIDTH-16){half_lane[15]}}, half_lane};
      LDT_LHU: load_data = {{(WIDTH-16){1'b0}}, half_lane};
      LDT_LW:  load_data = mem_q;
      default: load_data = mem_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit, write port, exception and retire counter
  // ---------------------------------------------------------------------------
  // An instruction commits on the cycle it leaves WB; a stalled instruction
  // stays put and commits later, so it is counted exactly once.
  assign commit = valid_q & ~stall;
  assign retire = commit & ~misalign;

  assign d     = m2reg_q ? load_data : alu_q;
  assign wn    = rn_q;
  // Register 0 is hard-wired to zero, so writes to it are suppressed here.
  assign we    = commit & wreg_q & (rn_q != 5'd0) & ~misalign;
  assign w_exc = commit & m2reg_q & misalign;

  // A write to r0 still retires; only bubbles, stalls and faulting loads
  // are excluded. The counter wraps naturally at 2^CNT_W.
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Two instances share all inputs: one with the default 32-bit counter and one
// with a 4-bit counter to exercise wrap-around. A behavioural model holds the
// instruction currently in WB and derives the expected write port from the
// load/store rules using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic        m_valid = 0, m_wreg = 0, m_m2reg = 0;
  logic [4:0]  m_rn = 0;
  logic [31:0] m_alu = 0, m_mem = 0;
  logic [2:0]  m_ldt = 0;
  logic        stall = 0, flush = 0;

  logic [31:0] d, d4;
  logic [4:0]  wn, wn4;
  logic        we, we4, w_exc, w_exc4;
  logic [31:0] instret;
  logic [3:0]  instret4;

  wb_stage #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .clr(clr), .m_valid(m_valid), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu), .m_mem(m_mem),
    .m_ldt(m_ldt), .stall(stall), .flush(flush), .d(d), .wn(wn), .we(we),
    .w_exc(w_exc), .instret(instret)
  );

  wb_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .clr(clr), .m_valid(m_valid), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu), .m_mem(m_mem),
    .m_ldt(m_ldt), .stall(stall), .flush(flush), .d(d4), .wn(wn4), .we(we4),
    .w_exc(w_exc4), .instret(instret4)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid, wreg, m2reg;
    logic [4:0]  rn;
    logic [31:0] alu, mem;
    logic [2:0]  ldt;
  } ins_t;

  ins_t        slot;
  int unsigned cnt;
  logic [36:0] exp_q[$];

  function automatic bit mdl_misalign(input ins_t i);
    if (!i.m2reg) return 0;
    case (i.ldt)
      3'd1, 3'd2: return 0;
      3'd3, 3'd4: return (i.alu % 2) != 0;
      default:    return (i.alu % 4) != 0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_data(input ins_t i);
    int unsigned off, b, h;
    if (!i.m2reg) return i.alu;
    off = i.alu % 4;
    b = (i.mem >> (8 * (3 - off))) & 32'hFF;
    h = (i.mem >> (16 * (1 - off / 2))) & 32'hFFFF;
    case (i.ldt)
      3'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return h;
      default: return i.mem;
    endcase
  endfunction

  task automatic model_reset();
    slot = '0;
    cnt  = 0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic present(input logic v, input logic wr, input logic m2, input logic [4:0] rn,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] ldt,
                         input logic st, input logic fl);
    m_valid = v; m_wreg = wr; m_m2reg = m2; m_rn = rn;
    m_alu = alu; m_mem = mem; m_ldt = ldt; stall = st; flush = fl;
  endtask

  task automatic idle();
    present(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check outputs at the falling edge against the model, then let
  // the model capture at the rising edge. Inputs must already be set.
  task automatic step();
    bit          cm, mis, ew, ex;
    logic [31:0] ed;
    ins_t        inc;
    @(negedge clk);
    mis = mdl_misalign(slot);
    cm  = slot.valid && !stall;
    ew  = cm && slot.wreg && slot.rn != 0 && !mis;
    ex  = cm && slot.m2reg && mis;
    ed  = mdl_data(slot);
    check("we", we, ew);
    check("w_exc", w_exc, ex);
    check("d", d, ed);
    check("wn", wn, slot.rn);
    check("instret", instret, cnt);
    check("instret4", instret4, cnt % 16);
    check("we4", we4, ew);
    if (ew) exp_q.push_back({slot.rn, ed});
    if (we) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else check("sb_write", {wn, d}, exp_q.pop_front());
    end
    inc = '{valid: m_valid, wreg: m_wreg, m2reg: m_m2reg, rn: m_rn,
            alu: m_alu, mem: m_mem, ldt: m_ldt};
    @(posedge clk);
    if (cm && !mis) cnt++;
    if (!stall) slot = flush ? '0 : inc;
    #1;
  endtask

  // Directed look at the instruction just captured, with stall low.
  task automatic peek(input string tag, input logic exp_we, input logic exp_exc,
                      input logic [31:0] exp_d);
    idle();
    #1;
    check({tag, "_we"}, we, exp_we);
    check({tag, "_exc"}, w_exc, exp_exc);
    check({tag, "_d"}, d, exp_d);
  endtask

  localparam logic [31:0] MEMW = 32'h80F17F02;

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] c0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_we", we, 0);
    check("rst_d", d, 0);
    check("rst_wn", wn, 0);
    check("rst_exc", w_exc, 0);
    check("rst_instret", instret, 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // ALU path
    present(1, 1, 0, 5, 32'h12345678, 0, 0, 0, 0);
    step();
    peek("alu", 1, 0, 32'h12345678);
    check("alu_wn", wn, 5);
    check("alu_instret0", instret, 0);
    step();
    check("alu_instret1", instret, 1);

    // Load extraction
    present(1, 1, 1, 7, 32'h00000101, MEMW, 3'd1, 0, 0); step(); peek("lb", 1, 0, 32'hFFFFFFF1); step();
    present(1, 1, 1, 7, 32'h00000101, MEMW, 3'd2, 0, 0); step(); peek("lbu", 1, 0, 32'h000000F1); step();
    present(1, 1, 1, 7, 32'h00000100, MEMW, 3'd3, 0, 0); step(); peek("lh", 1, 0, 32'hFFFF80F1); step();
    present(1, 1, 1, 7, 32'h00000102, MEMW, 3'd4, 0, 0); step(); peek("lhu", 1, 0, 32'h00007F02); step();
    present(1, 1, 1, 7, 32'h00000100, MEMW, 3'd0, 0, 0); step(); peek("lw", 1, 0, 32'h80F17F02); step();

    // Misaligned lw: no write, one exception pulse, count unchanged
    c0 = instret;
    present(1, 1, 1, 9, 32'h00001002, MEMW, 3'd0, 0, 0); step();
    peek("mis_lw", 0, 1, 32'h80F17F02);
    step();
    check("mis_exc_gone", w_exc, 0);
    check("mis_instret", instret, c0);
    // Misaligned lh
    present(1, 1, 1, 9, 32'h00001003, MEMW, 3'd3, 0, 0); step();
    peek("mis_lh", 0, 1, 32'h00007F02);
    step();

    // Write to r0: no write, still retires
    c0 = instret;
    present(1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0); step();
    peek("r0", 0, 0, 32'hDEADBEEF);
    step();
    check("r0_instret", instret, c0 + 1);

    // Stall held 3 cycles, with a flush in one of them
    c0 = instret;
    present(1, 1, 0, 3, 32'hCAFE0003, 0, 0, 0, 0); step();
    present(1, 1, 0, 4, 32'h11111111, 0, 0, 1, 0); step();
    present(1, 1, 0, 4, 32'h22222222, 0, 0, 1, 1); step();
    present(1, 1, 0, 4, 32'h33333333, 0, 0, 1, 0); step();
    check("stall_held_d", d, 32'hCAFE0003);
    check("stall_instret", instret, c0);
    present(1, 1, 0, 6, 32'h66666666, 0, 0, 0, 1); step();   // commits held; flush incoming
    check("stall_commit_instret", instret, c0 + 1);
    step();                                                   // bubble: no write, no count
    check("flush_bubble_instret", instret, c0 + 1);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) begin
      present(1, 1, 0, 5'(10 + i), 32'hA0 + i, 0, 0, 0, 0);
      step();
    end
    #2 clr = 1'b1;
    #1;
    check("mrst_we", we, 0);
    check("mrst_d", d, 0);
    check("mrst_wn", wn, 0);
    check("mrst_instret", instret, 0);
    model_reset();
    @(posedge clk);
    #2 clr = 1'b0;
    present(1, 1, 0, 12, 32'h0BADF00D, 0, 0, 0, 0); step();
    peek("post_rst", 1, 0, 32'h0BADF00D);
    step();

    // Counter wrap on the 4-bit instance
    clr = 1'b1; #1 clr = 1'b0;
    model_reset();
    for (int i = 0; i < 17; i++) begin
      present(1, 1, 0, 5'(1 + i % 31), 32'h100 + i, 0, 0, 0, 0);
      step();
    end
    idle(); step();
    check("wrap_instret4", instret4, 4'd1);
    check("wrap_instret32", instret, 17);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      present($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 1),
              5'($urandom_range(0, 31)), $urandom, $urandom, 3'($urandom_range(0, 7)),
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      step();
    end
    idle(); step(); step();
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
